lap_timer: RTL and testbench
============================

# lap_timer

Race bookkeeping block downstream of the checkpoint/lap detector. It consumes the detector's `lap_finished` and `checkpoints_passed` levels and accepts a lap only when all checkpoints were passed. It counts laps, times the current lap in centiseconds, and records the last and best lap times. It flags race completion after a configurable number of laps for the HUD/overlay logic.

## Interface
Parameters:
- `CLK_HZ`, 65_000_000: pclk frequency in Hz (1024x768@60 pixel clock).
- `LAPS`, 3: laps per race, range 1..15.
- `TIME_W`, 16: width of time outputs, in centiseconds.

Ports:
- `pclk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `race_start`  in  1: single-cycle start/restart pulse.
- `lap_finished`  in  1: level from the detector; high while the car is in the finish zone.
- `checkpoints_passed`  in  1: level from the detector; high while all 6 checkpoints are latched.
- `lap_count`  out  4: completed valid laps.
- `lap_time`  out  TIME_W: running time of the current lap.
- `last_time`  out  TIME_W: time of the most recent completed lap.
- `best_time`  out  TIME_W: best completed lap; all-ones means no lap yet.
- `new_best`  out  1: one-cycle pulse when `best_time` improves.
- `race_active`  out  1: high in RUNNING.
- `race_finished`  out  1: high in FINISHED.

## Operation
- Prescaler: counter 0..`CLK_HZ/100`-1. `tick` is asserted for one cycle at terminal count. The prescaler runs only in RUNNING and is cleared on any accepted `race_start`.
- Edge detect: `lf_q` holds `lap_finished` delayed one cycle. `lap_evt = lap_finished & ~lf_q & checkpoints_passed`, with `checkpoints_passed` sampled in the same cycle as the rising edge.
  - The detector clears its checkpoints after `lap_finished` rises, so later cycles are invalid.
  - A rising edge without `checkpoints_passed` is ignored; this covers the car sitting on the start line at race start.
- FSM states: IDLE, RUNNING, FINISHED.
  - IDLE: all timers hold; `lap_evt` is ignored. `race_start` -> RUNNING, with `lap_count`=0, `lap_time`=0, `last_time`=0, `best_time`=all-ones.
  - RUNNING:
    - On `tick`, `lap_time` increments, saturating at all-ones; it never wraps.
    - On `lap_evt`:
      - `last_time`<=`lap_time`.
      - If `lap_time` < `best_time`, then `best_time`<=`lap_time` and `new_best` pulses next cycle.
      - `lap_time`<=0 and `lap_count`++.
      - If the new count equals `LAPS` -> FINISHED.
  - FINISHED: all outputs hold; `lap_evt` is ignored. `race_start` -> RUNNING with the same clears as from IDLE.
  - `race_start` in RUNNING restarts the race: same clears, stays in RUNNING.
- Comparison is strict `<`, so an equal time does not update `best_time` or pulse `new_best`.
- A saturated `lap_time` is still accepted as a lap time.

## Timing
- Reset values: state=IDLE; `lap_count`=0, `lap_time`=0, `last_time`=0; `best_time`=all-ones; `new_best`=0, `race_active`=0, `race_finished`=0; prescaler=0; `lf_q`=0.
- All outputs are registered. `lap_evt` in cycle N makes `lap_count`, `last_time` and `best_time` visible at edge N+1. `new_best` is high exactly during cycle N+1.
- Simultaneous events:
  - `tick` and `lap_evt` in the same cycle: `lap_evt` wins, `lap_time`<=0 and the tick is dropped, and `last_time` takes the pre-increment value.
  - `race_start` and `lap_evt` in the same cycle: `race_start` wins and the lap is discarded.
- `race_start` takes effect at the next edge. The first `tick` comes `CLK_HZ/100` cycles after that edge.
- `rst` mid-race returns to the reset values asynchronously. Timing restarts only after a new `race_start`.

## Structure
- Shared package `race_pkg`:
  - FSM state encoding (IDLE=2'd0, RUNNING=2'd1, FINISHED=2'd2).
  - `CS_PER_SEC`=100.
  - `NO_TIME` (all-ones) constant.
  - Checkpoint count (6).
- Sub-module `cs_tick_gen` holds the prescaler, with inputs `pclk`, `rst`, `en`, `clr` and output `tick`; its divider comes from `CLK_HZ`.
- The rest (edge detect, FSM, time registers) stays in `lap_timer`.

## Test plan
Benches use `CLK_HZ`=1000 (tick every 10 cycles) and `LAPS`=3.
- Reset, no start: pulse `lap_finished` with `checkpoints_passed`=1 -> state IDLE, `lap_count`=0, `best_time`=16'hFFFF, `race_active`=0.
- Start with the car on the line: `race_start`, then `lap_finished` rises with `checkpoints_passed`=0 -> no lap counted; after 50 cycles `lap_time`=5.
- Valid laps of 120, 80 and 80 ticks -> after lap 2, `last_time`=80, `best_time`=80 and `new_best` pulses once; after lap 3, `best_time`=80 and `new_best` stays 0.
  - Also after lap 3: `lap_count`=3, `race_finished`=1, and `lap_time` frozen at 0.
- `lap_evt` on the same cycle as `tick` with `lap_time`=41 -> `last_time`=41 and `lap_time`=0 the next cycle.
- `race_start` mid-lap with `lap_count`=1 and `lap_time`=30 -> next cycle `lap_count`=0, `lap_time`=0, `best_time`=16'hFFFF, still RUNNING.
- Saturation with `TIME_W`=4: hold 20 ticks -> `lap_time`=15 and stays 15. Assert `rst` mid-race -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/race_pkg.sv
// -----------------------------------------------------------------------------
// race_pkg
// Shared definitions for the race bookkeeping logic: FSM state encoding,
// timebase constant, the "no lap yet" time value and the checkpoint count.
// No ports (package).
// -----------------------------------------------------------------------------
package race_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_FINISHED = 2'd2
   } race_state_t;

   // Lap times are kept in centiseconds.
   localparam int CS_PER_SEC = 100;

   // All-ones marks "no lap recorded yet"; slice to the time width in use.
   localparam logic [31:0] NO_TIME = 32'hFFFF_FFFF;

   // Checkpoints the upstream detector must latch before a lap is valid.
   localparam int NUM_CHECKPOINTS = 6;

endpackage : race_pkg

// File: rtl/cs_tick_gen.sv
// -----------------------------------------------------------------------------
// cs_tick_gen
// Centisecond prescaler. Counts pclk cycles 0..CLK_HZ/100-1 while enabled and
// raises tick for one cycle at the terminal count.
// Ports:
//   pclk  in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   en    in  count enable (race running)
//   clr   in  synchronous clear (accepted race start)
//   tick  out one-cycle centisecond strobe
// -----------------------------------------------------------------------------
module cs_tick_gen
   import race_pkg::*;
#(
   parameter int CLK_HZ = 65_000_000
) (
   input  logic pclk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV   = CLK_HZ / CS_PER_SEC;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = en && (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : cs_tick_gen

// File: rtl/lap_timer.sv
// -----------------------------------------------------------------------------
// lap_timer
// Race bookkeeping: accepts a lap on the rising edge of lap_finished only when
// checkpoints_passed is high in that same cycle, counts laps, times the
// current lap in centiseconds and keeps last/best lap times.
// Ports:
//   pclk               in  system clock, rising edge
//   rst                in  asynchronous active-high reset
//   race_start         in  single-cycle start/restart pulse
//   lap_finished       in  detector level, high while in finish zone
//   checkpoints_passed in  detector level, high while all checkpoints latched
//   lap_count          out completed valid laps
//   lap_time           out running time of current lap (saturating)
//   last_time          out time of most recent completed lap
//   best_time          out best lap time, all-ones = no lap yet
//   new_best           out one-cycle pulse when best_time improves
//   race_active        out high while RUNNING
//   race_finished      out high while FINISHED
// -----------------------------------------------------------------------------
module lap_timer
   import race_pkg::*;
#(
   parameter int CLK_HZ = 65_000_000,
   parameter int LAPS   = 3,
   parameter int TIME_W = 16
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              race_start,
   input  logic              lap_finished,
   input  logic              checkpoints_passed,
   output logic [3:0]        lap_count,
   output logic [TIME_W-1:0] lap_time,
   output logic [TIME_W-1:0] last_time,
   output logic [TIME_W-1:0] best_time,
   output logic              new_best,
   output logic              race_active,
   output logic              race_finished
);

   localparam logic [TIME_W-1:0] TMAX   = NO_TIME[TIME_W-1:0];
   localparam logic [3:0]        LAPS_C = 4'(LAPS);

   race_state_t       state_q, state_d;
   logic              lf_q;
   logic [3:0]        lap_count_q, lap_count_d;
   logic [TIME_W-1:0] lap_time_q, lap_time_d;
   logic [TIME_W-1:0] last_time_q, last_time_d;
   logic [TIME_W-1:0] best_time_q, best_time_d;
   logic              new_best_q, new_best_d;
   logic              race_active_q, race_active_d;
   logic              race_finished_q, race_finished_d;
   logic              tick;
   logic              lap_evt;
   logic              running;

   assign running = (state_q == ST_RUNNING);

   // Checkpoints are only trustworthy in the rising-edge cycle; the detector
   // clears them right after lap_finished goes high.
   assign lap_evt = lap_finished & ~lf_q & checkpoints_passed;

   cs_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .pclk (pclk),
      .rst  (rst),
      .en   (running),
      .clr  (race_start),
      .tick (tick)
   );

   // State register.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; race_start is accepted in every state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (race_start) state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (race_start) begin
               state_d = ST_RUNNING;
            end else if (lap_evt && ((lap_count_q + 4'd1) == LAPS_C)) begin
               state_d = ST_FINISHED;
            end
         end
         ST_FINISHED: begin
            if (race_start) state_d = ST_RUNNING;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: status flags follow the next state so they are registered
   // in step with the state register.
   always_comb begin
      race_active_d   = (state_d == ST_RUNNING);
      race_finished_d = (state_d == ST_FINISHED);
   end

   // Time and lap registers. race_start beats lap_evt, and lap_evt beats tick
   // so last_time captures the pre-increment value.
   always_comb begin
      lap_count_d = lap_count_q;
      lap_time_d  = lap_time_q;
      last_time_d = last_time_q;
      best_time_d = best_time_q;
      new_best_d  = 1'b0;
      if (race_start) begin
         lap_count_d = '0;
         lap_time_d  = '0;
         last_time_d = '0;
         best_time_d = TMAX;
      end else if (running) begin
         if (lap_evt) begin
            last_time_d = lap_time_q;
            if (lap_time_q < best_time_q) begin
               best_time_d = lap_time_q;
               new_best_d  = 1'b1;
            end
            lap_time_d  = '0;
            lap_count_d = lap_count_q + 4'd1;
         end else if (tick && (lap_time_q != TMAX)) begin
            lap_time_d = lap_time_q + 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         lf_q            <= 1'b0;
         lap_count_q     <= '0;
         lap_time_q      <= '0;
         last_time_q     <= '0;
         best_time_q     <= TMAX;
         new_best_q      <= 1'b0;
         race_active_q   <= 1'b0;
         race_finished_q <= 1'b0;
      end else begin
         lf_q            <= lap_finished;
         lap_count_q     <= lap_count_d;
         lap_time_q      <= lap_time_d;
         last_time_q     <= last_time_d;
         best_time_q     <= best_time_d;
         new_best_q      <= new_best_d;
         race_active_q   <= race_active_d;
         race_finished_q <= race_finished_d;
      end
   end

   assign lap_count     = lap_count_q;
   assign lap_time      = lap_time_q;
   assign last_time     = last_time_q;
   assign best_time     = best_time_q;
   assign new_best      = new_best_q;
   assign race_active   = race_active_q;
   assign race_finished = race_finished_q;

endmodule : lap_timer

// File: tb/tb_lap_timer.sv
// -----------------------------------------------------------------------------
// tb_lap_timer
// Directed bench for lap_timer: a 16-bit instance for the race sequence and a
// 4-bit instance for saturation and asynchronous reset. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lap_timer;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Main instance
   logic        rst, race_start, lap_finished, checkpoints_passed;
   logic [3:0]  lap_count;
   logic [15:0] lap_time, last_time, best_time;
   logic        new_best, race_active, race_finished;

   // Narrow instance
   logic        rst_s, start_s, lf_s, cp_s;
   logic [3:0]  lap_count_s;
   logic [3:0]  lap_time_s, last_time_s, best_time_s;
   logic        new_best_s, active_s, finished_s;

   int tests = 0;
   int fails = 0;

   lap_timer #(.CLK_HZ(1000), .LAPS(3), .TIME_W(16)) u_dut (
      .pclk               (pclk),
      .rst                (rst),
      .race_start         (race_start),
      .lap_finished       (lap_finished),
      .checkpoints_passed (checkpoints_passed),
      .lap_count          (lap_count),
      .lap_time           (lap_time),
      .last_time          (last_time),
      .best_time          (best_time),
      .new_best           (new_best),
      .race_active        (race_active),
      .race_finished      (race_finished)
   );

   lap_timer #(.CLK_HZ(1000), .LAPS(3), .TIME_W(4)) u_sat (
      .pclk               (pclk),
      .rst                (rst_s),
      .race_start         (start_s),
      .lap_finished       (lf_s),
      .checkpoints_passed (cp_s),
      .lap_count          (lap_count_s),
      .lap_time           (lap_time_s),
      .last_time          (last_time_s),
      .best_time          (best_time_s),
      .new_best           (new_best_s),
      .race_active        (active_s),
      .race_finished      (finished_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge pclk);
   endtask

   initial begin
      rst = 1'b1; race_start = 1'b0; lap_finished = 1'b0; checkpoints_passed = 1'b0;
      rst_s = 1'b1; start_s = 1'b0; lf_s = 1'b0; cp_s = 1'b0;
      step(3);
      rst = 1'b0; rst_s = 1'b0;
      step(1);

      // Reset state
      chk("rst_lap_count", 32'(lap_count), 0);
      chk("rst_lap_time", 32'(lap_time), 0);
      chk("rst_last_time", 32'(last_time), 0);
      chk("rst_best_time", 32'(best_time), 32'hFFFF);
      chk("rst_new_best", 32'(new_best), 0);
      chk("rst_active", 32'(race_active), 0);
      chk("rst_finished", 32'(race_finished), 0);

      // Lap edge while IDLE is ignored
      lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      lap_finished = 1'b0; checkpoints_passed = 1'b0;
      step(2);
      chk("idle_lap_count", 32'(lap_count), 0);
      chk("idle_best_time", 32'(best_time), 32'hFFFF);
      chk("idle_active", 32'(race_active), 0);
      chk("idle_lap_time", 32'(lap_time), 0);

      // Start with the car on the line (edge without checkpoints)
      race_start = 1'b1;
      step(1);                       // just after edge E0
      race_start = 1'b0; lap_finished = 1'b1; checkpoints_passed = 1'b0;
      chk("start_active", 32'(race_active), 1);
      step(50);                      // after E50
      lap_finished = 1'b0;
      chk("online_lap_count", 32'(lap_count), 0);
      chk("online_lap_time", 32'(lap_time), 5);

      // Lap 1: 120 ticks
      step(1155);                    // cycle 1205
      chk("lap1_pre_time", 32'(lap_time), 120);
      lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      lap_finished = 1'b0; checkpoints_passed = 1'b0;
      chk("lap1_count", 32'(lap_count), 1);
      chk("lap1_last", 32'(last_time), 120);
      chk("lap1_best", 32'(best_time), 120);
      chk("lap1_new_best", 32'(new_best), 1);
      chk("lap1_lap_time", 32'(lap_time), 0);
      step(1);
      chk("lap1_new_best_drop", 32'(new_best), 0);

      // Lap 2: 80 ticks, improves best
      step(798);                     // cycle 2005
      lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      lap_finished = 1'b0; checkpoints_passed = 1'b0;
      chk("lap2_count", 32'(lap_count), 2);
      chk("lap2_last", 32'(last_time), 80);
      chk("lap2_best", 32'(best_time), 80);
      chk("lap2_new_best", 32'(new_best), 1);
      step(1);
      chk("lap2_new_best_once", 32'(new_best), 0);

      // Lap 3: 80 ticks, equal to best, finishes race
      step(798);                     // cycle 2805
      lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      lap_finished = 1'b0; checkpoints_passed = 1'b0;
      chk("lap3_count", 32'(lap_count), 3);
      chk("lap3_last", 32'(last_time), 80);
      chk("lap3_best", 32'(best_time), 80);
      chk("lap3_new_best", 32'(new_best), 0);
      chk("lap3_finished", 32'(race_finished), 1);
      chk("lap3_active", 32'(race_active), 0);
      step(20);
      chk("fin_lap_time_frozen", 32'(lap_time), 0);
      lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      lap_finished = 1'b0; checkpoints_passed = 1'b0;
      step(1);
      chk("fin_lap_ignored", 32'(lap_count), 3);
      chk("fin_still_finished", 32'(race_finished), 1);

      // Restart from FINISHED
      race_start = 1'b1;
      step(1);                       // after new E0
      race_start = 1'b0;
      chk("restart_count", 32'(lap_count), 0);
      chk("restart_best", 32'(best_time), 32'hFFFF);
      chk("restart_last", 32'(last_time), 0);
      chk("restart_active", 32'(race_active), 1);
      chk("restart_finished", 32'(race_finished), 0);

      // lap_evt in the same cycle as a tick (cycle 419, lap_time 41)
      step(419);
      chk("tickevt_pre_time", 32'(lap_time), 41);
      lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      lap_finished = 1'b0; checkpoints_passed = 1'b0;
      chk("tickevt_last", 32'(last_time), 41);
      chk("tickevt_lap_time", 32'(lap_time), 0);
      chk("tickevt_count", 32'(lap_count), 1);

      // race_start mid-lap with lap_count 1, lap_time 30
      step(300);
      chk("mid_pre_time", 32'(lap_time), 30);
      race_start = 1'b1;
      step(1);
      race_start = 1'b0;
      chk("mid_count", 32'(lap_count), 0);
      chk("mid_lap_time", 32'(lap_time), 0);
      chk("mid_best", 32'(best_time), 32'hFFFF);
      chk("mid_active", 32'(race_active), 1);

      // race_start and lap_evt together: the lap is discarded
      step(5);
      race_start = 1'b1; lap_finished = 1'b1; checkpoints_passed = 1'b1;
      step(1);
      race_start = 1'b0; lap_finished = 1'b0; checkpoints_passed = 1'b0;
      chk("startevt_count", 32'(lap_count), 0);
      chk("startevt_best", 32'(best_time), 32'hFFFF);
      chk("startevt_new_best", 32'(new_best), 0);

      // Saturation on the 4-bit instance
      start_s = 1'b1;
      step(1);
      start_s = 1'b0;
      step(200);
      chk("sat_lap_time", 32'(lap_time_s), 15);
      step(50);
      chk("sat_lap_time_hold", 32'(lap_time_s), 15);
      chk("sat_best", 32'(best_time_s), 32'hF);

      // Asynchronous reset mid-race, checked between clock edges
      #2 rst_s = 1'b1;
      #1;
      chk("arst_lap_time", 32'(lap_time_s), 0);
      chk("arst_count", 32'(lap_count_s), 0);
      chk("arst_last", 32'(last_time_s), 0);
      chk("arst_best", 32'(best_time_s), 32'hF);
      chk("arst_active", 32'(active_s), 0);
      chk("arst_finished", 32'(finished_s), 0);
      chk("arst_new_best", 32'(new_best_s), 0);
      step(1);
      rst_s = 1'b0;
      step(30);
      chk("post_rst_idle_time", 32'(lap_time_s), 0);
      chk("post_rst_idle_active", 32'(active_s), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_lap_timer
